// File: rtl/fcvt_s_w.sv
// Two-stage int32 -> binary32 converter (RISC-V FCVT.S.W, round-to-nearest-even).
// Stage 1 captures sign, magnitude and leading-one position; stage 2 normalises, rounds, packs.
module fcvt_s_w (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] x,
  output logic [31:0] y
);

  // Stage 1 state
  logic        sign_q, sign_d;
  logic [31:0] mag_q, mag_d;
  logic [4:0]  pos_q, pos_d;

  // Stage 2 state
  logic [31:0] y_q, y_d;

  // Stage 1: sign, magnitude and leading-one detection.
  always_comb begin
    sign_d = x[31];
    // Two's-complement negate; 0x80000000 maps to itself, i.e. 2^31 unsigned.
    mag_d  = x[31] ? (~x + 32'd1) : x;
    pos_d  = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (mag_d[i]) begin
        pos_d = 5'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sign_q <= 1'b0;
      mag_q  <= '0;
      pos_q  <= '0;
    end else begin
      sign_q <= sign_d;
      mag_q  <= mag_d;
      pos_q  <= pos_d;
    end
  end

  // Stage 2 datapath
  logic [31:0] norm;
  logic [22:0] mant;
  logic        guard;
  logic        sticky;
  logic        round_up;
  logic [23:0] mant_rnd;
  logic [7:0]  exp_biased;

  always_comb begin
    // Leading one lands on bit 31; below it sit 23 fraction bits, then guard and sticky.
    norm       = mag_q << (5'd31 - pos_q);
    mant       = norm[30:8];
    guard      = norm[7];
    sticky     = |norm[6:0];
    round_up   = guard & (sticky | mant[0]);
    mant_rnd   = {1'b0, mant} + {23'd0, round_up};
    // A fraction carry-out means the value became the next power of two.
    exp_biased = 8'd127 + {3'd0, pos_q} + {7'd0, mant_rnd[23]};

    if (mag_q == 32'd0) begin
      y_d = 32'd0;
    end else begin
      y_d = {sign_q, exp_biased, (mant_rnd[23] ? 23'd0 : mant_rnd[22:0])};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: tb/tb_fcvt_s_w.sv
// Bench for fcvt_s_w: directed literals, pipeline streaming, mid-stream reset and random
// operands, all checked every cycle against an arithmetic int-to-float model.
module tb_fcvt_s_w;

  logic        clk;
  logic        rstn;
  logic [31:0] x;
  logic [31:0] y;

  int unsigned n_vec;
  int unsigned n_bad;

  logic [31:0] cur_lit;
  bit          cur_has;

  typedef struct {
    logic [31:0] xin;
    logic [31:0] exp_y;
    logic [31:0] lit;
    bit          has_lit;
  } samp_t;

  samp_t sq[$];

  fcvt_s_w dut (
    .clk  (clk),
    .rstn (rstn),
    .x    (x),
    .y    (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact integer arithmetic, RNE on the remainder after dividing to 24 bits.
  function automatic logic [31:0] model(input logic [31:0] v);
    longint m, pw, d, q, r, half, frac;
    int     p;
    logic   s;
    logic [7:0] e;
    if (v == 32'd0) return 32'd0;
    s = v[31];
    m = s ? (longint'(64'h1_0000_0000) - longint'({32'd0, v})) : longint'({32'd0, v});
    pw = 1;
    p  = 0;
    while (pw * 2 <= m) begin
      pw = pw * 2;
      p  = p + 1;
    end
    if (p <= 23) begin
      frac = (m - pw) * (longint'(1) << (23 - p));
    end else begin
      d    = longint'(1) << (p - 23);
      q    = m / d;
      r    = m % d;
      half = d / 2;
      if (r > half || (r == half && (q % 2) == 1)) q = q + 1;
      if (q == (longint'(1) << 24)) begin
        q = q / 2;
        p = p + 1;
      end
      frac = q - (longint'(1) << 23);
    end
    e = 8'(127 + p);
    return {s, e, frac[22:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, expv, $time);
    end
  endtask

  // Sample what the DUT sees on each active edge.
  always @(posedge clk) begin
    if (rstn) begin
      sq.push_back('{xin: x, exp_y: model(x), lit: cur_lit, has_lit: cur_has});
      if (sq.size() > 2) void'(sq.pop_front());
    end
  end

  always @(negedge rstn) sq.delete();

  // Single compare process, mid-cycle.
  always @(negedge clk) begin
    if (!rstn || sq.size() < 2) begin
      chk("idle_zero", y, 32'd0);
    end else begin
      chk("model", y, sq[0].exp_y);
      if (sq[0].has_lit) chk("literal", y, sq[0].lit);
    end
  end

  logic [31:0] dir_x   [14];
  logic [31:0] dir_lit [14];

  task automatic drive(input logic [31:0] v, input logic [31:0] lit, input bit has);
    x       = v;
    cur_lit = lit;
    cur_has = has;
    @(posedge clk);
    #2;
  endtask

  initial begin
    n_vec   = 0;
    n_bad   = 0;
    rstn    = 1'b0;
    x       = 32'd0;
    cur_lit = 32'd0;
    cur_has = 1'b0;

    dir_x[0]  = 32'd1;          dir_lit[0]  = 32'h3F800000;
    dir_x[1]  = 32'hFFFFFFFF;   dir_lit[1]  = 32'hBF800000;
    dir_x[2]  = 32'd0;          dir_lit[2]  = 32'h00000000;
    dir_x[3]  = 32'h7FFFFFFF;   dir_lit[3]  = 32'h4F000000;
    dir_x[4]  = 32'h80000000;   dir_lit[4]  = 32'hCF000000;
    dir_x[5]  = 32'd16777217;   dir_lit[5]  = 32'h4B800000;
    dir_x[6]  = 32'd16777219;   dir_lit[6]  = 32'h4B800002;
    dir_x[7]  = 32'hFEFFFFFD;   dir_lit[7]  = 32'hCB800002;
    dir_x[8]  = 32'd8388607;    dir_lit[8]  = 32'h4AFFFFFE;
    dir_x[9]  = 32'd16777216;   dir_lit[9]  = 32'h4B800000;
    dir_x[10] = 32'd2;          dir_lit[10] = 32'h40000000;
    dir_x[11] = 32'd3;          dir_lit[11] = 32'h40400000;
    dir_x[12] = 32'hFFFFFFF6;   dir_lit[12] = 32'hC1200000;
    dir_x[13] = 32'd16777218;   dir_lit[13] = 32'h4B800001;

    // Pin the model to hand-computed values.
    for (int i = 0; i < 14; i++) chk("model_pin", model(dir_x[i]), dir_lit[i]);

    repeat (3) @(posedge clk);
    #2;
    rstn = 1'b1;

    // Back-to-back directed vectors double as the streaming check.
    for (int i = 0; i < 14; i++) drive(dir_x[i], dir_lit[i], 1'b1);

    // Powers of two and neighbours, both signs.
    for (int k = 0; k < 31; k++) begin
      drive(32'd1 << k, 32'd0, 1'b0);
      drive((32'd1 << k) + 32'd1, 32'd0, 1'b0);
      drive(-((32'd1 << k) + 32'd1), 32'd0, 1'b0);
    end

    // Reset mid-stream: y must clear immediately and stay 0 for two edges after release.
    for (int i = 0; i < 4; i++) drive(32'h12345678 + 32'(i), 32'd0, 1'b0);
    rstn = 1'b0;
    #1;
    chk("reset_async", y, 32'd0);
    drive(32'h0000ABCD, 32'd0, 1'b0);
    drive(32'h7FFFFFFF, 32'd0, 1'b0);
    rstn = 1'b1;
    drive(32'd1, 32'h3F800000, 1'b1);
    drive(32'h80000000, 32'hCF000000, 1'b1);

    for (int i = 0; i < 4000; i++) drive($urandom, 32'd0, 1'b0);
    for (int i = 0; i < 1000; i++) drive($urandom >> $urandom_range(31, 0), 32'd0, 1'b0);

    drive(32'd0, 32'd0, 1'b0);
    drive(32'd0, 32'd0, 1'b0);
    drive(32'd0, 32'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
